pwm_config_sequencer: RTL
=========================

// Module: pwm_config_sequencer
// PURPOSE
//  Avalon-MM controlled PWM channel controller. Holds shadow copies of prescale (division), period and duty.
//  Generates its own prescaled tick, runs the period counter and drives pwm_out.
//  Commits new settings to the active set only at a period boundary, so reconfiguration is glitch-free.
//  Also drives division_value to the existing PWM clock divider.
// PARAMETERS
//  CNT_WIDTH  16  width of period/duty counters and registers (8..32)
// PORTS
//  clock_in        in   1          single system clock; all logic on rising edge
//  reset_n         in   1          asynchronous, active-low reset
//  address         in   2          0=CTRL 1=DIV 2=PERIOD 3=DUTY
//  write           in   1          Avalon write strobe, zero wait states
//  writedata       in   32         write data
//  read            in   1          Avalon read strobe
//  readdata        out  32         read data, valid 1 cycle after read (fixed readLatency=1)
//  division_value  out  8          active prescale exponent, fed to the clock divider
//  pwm_out         out  1          PWM output
//  period_end      out  1          1-cycle pulse on the tick that wraps the period counter
//  update_pending  out  1          shadow commit requested, not yet applied
// BEHAVIOUR
//  Reset (reset_n=0, async): all registers 0; readdata=0, division_value=0, pwm_out=0, period_end=0, update_pending=0.
//  CTRL write fields: bit0 enable; bit1 update (write-1 request, self-clearing, reads 0); bit2 polarity.
//  CTRL read: {28'b0, update_pending, polarity, 1'b0, enable}.
//  DIV/PERIOD/DUTY writes update shadow regs only; reads return the shadow value.
//  - DIV writes [7:0]; values >8 are clamped to 8 when written.
//  - PERIOD/DUTY write [CNT_WIDTH-1:0]; upper bits read 0.
//  States: IDLE (enable=0), RUN (enable=1, no request), PEND (enable=1, request outstanding).
//  IDLE:
//  - presc=0, cnt=0, pwm_out=polarity, period_end=0.
//  - An update request commits shadow->active on the next cycle; update_pending high exactly 1 cycle.
//  IDLE->RUN on enable write 1:
//  - shadow always committed to active in the same edge, presc=0, cnt=0, pending cleared.
//  RUN/PEND->IDLE on enable write 0:
//  - counters cleared immediately; a pending request stays pending and commits in IDLE next cycle.
//  Tick:
//  - active_div=0: tick every cycle.
//  - otherwise presc counts 0..(2^active_div - 1), tick when presc == 2^active_div - 1, then presc wraps to 0.
//  Period counter: advances on tick. On a tick with cnt==active_period:
//  - cnt<=0, period_end pulses in the same cycle (combinational from tick & wrap).
//  - In PEND, that edge also commits shadow->active, presc<=0, ->RUN.
//  pwm_out = polarity XOR (cnt < active_duty), registered.
//  - duty=0 -> constant polarity level.
//  - duty>period -> constant active level.
//  - period=0 -> wrap every tick.
//  Update request in RUN -> PEND.
//  - Request on the same cycle as a wrap is NOT served by that wrap; it waits for the next one.
//  - Repeated requests while in PEND stay in PEND; the commit uses the latest shadow values.
//  Shadow write on a commit edge: commit takes the pre-write value; the new value waits for the next request.
//  division_value = active_div; changes only at commit edges (never mid-period).
//  Write and read in the same cycle are legal and independent.
// TESTING
//  1. Reset release, no writes -> readdata=0, pwm_out=0, division_value=0, period_end never pulses.
//  2. DIV=0, PERIOD=9, DUTY=3, CTRL=1 -> pwm_out high 3 cycles of every 10; period_end every 10 cycles.
//  3. Running, then DIV=2, DUTY=7, CTRL=3 mid-period:
//     - update_pending=1 until the wrap; old waveform holds until then.
//     - Afterwards tick every 4 cycles, high 28 of 40 cycles; division_value=2.
//  4. Edge cases:
//     - Update request on the exact wrap cycle -> commit at the following wrap.
//     - DUTY=12 with PERIOD=9 -> pwm_out constantly 1.
//     - DUTY=0 -> pwm_out constantly 0.
//  5. polarity=1, DUTY=3, PERIOD=9 -> pwm_out inverted.
//     - CTRL=4 (disable) -> pwm_out=1 next cycle, counters 0.
//     - DIV write 0xFF -> reads back 8.
//  6. Assert reset_n low mid-PEND -> all outputs 0 asynchronously; after release state is IDLE, CTRL reads 0.

Source files
------------

// File: rtl/pwm_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_config_sequencer
// Brief    : Avalon-MM PWM channel with shadow registers committed glitch-free
//            at period boundaries; drives the external divider exponent.
// Revision : 1.0
// ============================================================================
module pwm_config_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic [7:0]  division_value,
    output logic        pwm_out,
    output logic        period_end,
    output logic        update_pending
);

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_DIV    = 2'd1;
    localparam logic [1:0] c_ADDR_PERIOD = 2'd2;
    localparam logic [1:0] c_ADDR_DUTY   = 2'd3;
    localparam logic [7:0] c_DIV_MAX     = 8'd8;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_pend;
    logic                   r_pol;
    logic [7:0]             r_sh_div;
    logic [CNT_WIDTH-1:0]   r_sh_period;
    logic [CNT_WIDTH-1:0]   r_sh_duty;
    logic [7:0]             r_act_div;
    logic [CNT_WIDTH-1:0]   r_act_period;
    logic [CNT_WIDTH-1:0]   r_act_duty;
    logic [7:0]             r_presc;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_pwm;
    logic [31:0]            r_rdata;

    logic                   w_ctrl_wr;
    logic                   w_ctrl_en;
    logic                   w_ctrl_req;
    logic                   w_pend_nxt;
    logic                   w_commit;
    logic                   w_clr;
    logic                   w_tick;
    logic                   w_wrap;
    logic [7:0]             w_presc_max;
    logic [7:0]             w_presc_nxt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic [CNT_WIDTH-1:0]   w_duty_nxt;
    logic                   w_pol_nxt;
    logic                   w_pwm_nxt;
    logic [7:0]             w_div_wdata;
    logic [31:0]            w_rd_mux;

    assign w_ctrl_wr  = write && (address == c_ADDR_CTRL);
    assign w_ctrl_en  = writedata[0];
    assign w_ctrl_req = w_ctrl_wr && writedata[1];

    // All-ones mask of width active_div; saturates to 0xFF at the maximum exponent of 8.
    assign w_presc_max = ~(8'hFF << r_act_div);
    assign w_tick      = (r_state != ST_IDLE) && (r_presc == w_presc_max);
    assign w_wrap      = w_tick && (r_cnt == r_act_period);

    assign w_div_wdata = (writedata[7:0] > c_DIV_MAX) ? c_DIV_MAX : writedata[7:0];

    generate
        if (CNT_WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:CNT_WIDTH];
        end
    endgenerate

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_commit    = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr = 1'b1;
                if (r_pend) begin
                    w_commit   = 1'b1;
                    w_pend_nxt = 1'b0;
                end
                if (w_ctrl_wr && w_ctrl_en) begin
                    w_state_nxt = ST_RUN;
                    w_commit    = 1'b1;
                    w_pend_nxt  = 1'b0;
                end else if (w_ctrl_req) begin
                    w_pend_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_ctrl_wr && !w_ctrl_en) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                    w_pend_nxt  = w_ctrl_req;
                end else if (w_ctrl_req) begin
                    // A wrap on this same edge is deliberately not used to serve the request.
                    w_state_nxt = ST_PEND;
                    w_pend_nxt  = 1'b1;
                end
            end
            ST_PEND: begin
                if (w_ctrl_wr && !w_ctrl_en) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                    w_pend_nxt  = 1'b1;
                end else if (w_wrap) begin
                    w_commit = 1'b1;
                    if (w_ctrl_req) begin
                        w_state_nxt = ST_PEND;
                        w_pend_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_pend_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_clr       = 1'b1;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_presc_nxt = r_presc;
        w_cnt_nxt   = r_cnt;
        if (w_clr) begin
            w_presc_nxt = 8'd0;
            w_cnt_nxt   = '0;
        end else if (w_tick) begin
            w_presc_nxt = 8'd0;
            w_cnt_nxt   = w_wrap ? '0 : (r_cnt + c_CNT_ONE);
        end else begin
            w_presc_nxt = r_presc + 8'd1;
        end
    end

    // The output register is fed from next-state values so pwm_out always matches the live counter.
    assign w_pol_nxt  = w_ctrl_wr ? writedata[2] : r_pol;
    assign w_duty_nxt = w_commit ? r_sh_duty : r_act_duty;
    assign w_pwm_nxt  = (w_state_nxt == ST_IDLE) ? w_pol_nxt
                                                 : (w_pol_nxt ^ (w_cnt_nxt < w_duty_nxt));

    always_comb begin
        w_rd_mux = 32'd0;
        case (address)
            c_ADDR_CTRL:   w_rd_mux = {28'd0, r_pend, r_pol, 1'b0, (r_state != ST_IDLE)};
            c_ADDR_DIV:    w_rd_mux = {24'd0, r_sh_div};
            c_ADDR_PERIOD: w_rd_mux = 32'(r_sh_period);
            c_ADDR_DUTY:   w_rd_mux = 32'(r_sh_duty);
            default:       w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_pend       <= 1'b0;
            r_pol        <= 1'b0;
            r_sh_div     <= 8'd0;
            r_sh_period  <= '0;
            r_sh_duty    <= '0;
            r_act_div    <= 8'd0;
            r_act_period <= '0;
            r_act_duty   <= '0;
            r_presc      <= 8'd0;
            r_cnt        <= '0;
            r_pwm        <= 1'b0;
            r_rdata      <= 32'd0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_pol   <= w_pol_nxt;
            r_presc <= w_presc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pwm   <= w_pwm_nxt;
            r_rdata <= read ? w_rd_mux : 32'd0;
            if (w_commit) begin
                r_act_div    <= r_sh_div;
                r_act_period <= r_sh_period;
                r_act_duty   <= r_sh_duty;
            end
            if (write && (address == c_ADDR_DIV)) begin
                r_sh_div <= w_div_wdata;
            end
            if (write && (address == c_ADDR_PERIOD)) begin
                r_sh_period <= writedata[CNT_WIDTH-1:0];
            end
            if (write && (address == c_ADDR_DUTY)) begin
                r_sh_duty <= writedata[CNT_WIDTH-1:0];
            end
        end
    end

    assign readdata       = r_rdata;
    assign division_value = r_act_div;
    assign pwm_out        = r_pwm;
    assign period_end     = w_wrap;
    assign update_pending = r_pend;

endmodule
`default_nettype wire
